// File: rtl/io_port_pkg.sv
// Shared constants for the processor IO port: default geometry, IO address and status bit positions.
// No logic; imported by the port top level.
package io_port_pkg;

  localparam int         WIDTH          = 16;
  localparam int         DEPTH          = 4;
  localparam logic [7:0] IO_ADDR        = 8'd255;

  localparam int         ST_OVERFLOW    = 3;
  localparam int         ST_UNDERFLOW   = 2;
  localparam int         ST_RX_NONEMPTY = 1;
  localparam int         ST_TX_FULL     = 0;

endpackage

// File: rtl/io_fifo.sv
// Power-of-two FIFO with combinational head; push/pop take effect at the clock edge, zero-latency head view.
// A push while full is accepted only together with a pop; the caller decides whether to offer it.
module io_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rptr];
  // When full, the slot being overwritten is the one popped this same edge.
  assign w_push_en = push && (!full || pop);
  assign w_pop_en  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_push_en) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_en) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_en) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_device.sv
// Processor IO port: CPU writes feed a TX FIFO, external words fill an RX FIFO read back through a registered cpu_rdata (1 cycle).
// TX drains on tx_valid/tx_ready; rx_ready drops when RX is full or in reset; sticky overflow/underflow flags.
module io_port_device
  import io_port_pkg::*;
#(
  parameter int WIDTH = io_port_pkg::WIDTH,
  parameter int DEPTH = io_port_pkg::DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             clear_flags,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    w_tx_count;
  logic [CW-1:0]    w_rx_count;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [WIDTH-1:0] w_tx_head;
  logic [WIDTH-1:0] w_rx_head;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_rdata;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cpu_wr),
    .pop   (w_tx_pop),
    .din   (cpu_wdata),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count),
    .head  (w_tx_head)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (rx_data),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count),
    .head  (w_rx_head)
  );

  assign tx_valid  = !w_tx_empty;
  // Stale storage is masked so the bus reads zero whenever nothing is queued.
  assign tx_data   = w_tx_empty ? '0 : w_tx_head;
  assign w_tx_pop  = !w_tx_empty && tx_ready;

  assign rx_ready  = !w_rx_full && !reset;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = cpu_rd && !w_rx_empty;

  assign w_ovf_set = cpu_wr && w_tx_full && !w_tx_pop;
  assign w_udf_set = cpu_rd && w_rx_empty;
  assign cpu_rdata = r_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rdata     <= '0;
    end else begin
      // A set coinciding with clear keeps the flag.
      r_overflow  <= w_ovf_set || (r_overflow && !clear_flags);
      r_underflow <= w_udf_set || (r_underflow && !clear_flags);
      if (cpu_rd) begin
        r_rdata <= w_rx_empty ? '0 : w_rx_head;
      end
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_OVERFLOW]    = r_overflow;
    status[ST_UNDERFLOW]   = r_underflow;
    status[ST_RX_NONEMPTY] = (w_rx_count != '0);
    status[ST_TX_FULL]     = (w_tx_count == CW'(DEPTH));
  end

endmodule

// File: doc/io_port_device.md
IO_PORT_DEVICE -- requirements
Module: io_port_device

Interface
REQ-001 Parameter WIDTH, default 16, data word width of the IO port.
REQ-002 Parameter DEPTH, default 4, entries per FIFO, power of two, minimum 2.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cpu_wdata  input  WIDTH  word the processor writes to IO address 255.
REQ-006 Port cpu_wr  input  1  one-cycle strobe; processor IO write.
REQ-007 Port cpu_rd  input  1  one-cycle strobe; processor IO read.
REQ-008 Port cpu_rdata  output  WIDTH  registered word returned to the processor's io_in.
REQ-009 Port clear_flags  input  1  clears the sticky error flags.
REQ-010 Port status  output  4  {overflow, underflow, rx_nonempty, tx_full}.
REQ-011 Port tx_data  output  WIDTH  head word of the TX FIFO toward the external device.
REQ-012 Port tx_valid  output  1  TX FIFO not empty.
REQ-013 Port tx_ready  input  1  external sink accepts tx_data.
REQ-014 Port rx_data  input  WIDTH  word from the external source.
REQ-015 Port rx_valid  input  1  rx_data is valid.
REQ-016 Port rx_ready  output  1  RX FIFO not full.

Function
REQ-017 TX push: cpu_wr=1 with TX not full SHALL enqueue cpu_wdata at the next edge.
REQ-018 TX push: cpu_wr=1 with TX full and no same-cycle pop SHALL drop the word and set overflow.
REQ-019 TX pop: tx_valid&&tx_ready SHALL dequeue the head at the edge; tx_data SHALL show the next head the following cycle.
REQ-020 TX full with pop and cpu_wr in the same cycle SHALL accept the push and leave the count unchanged.
REQ-021 RX push: rx_valid&&rx_ready SHALL enqueue rx_data; rx_ready SHALL be combinational !rx_full.
REQ-022 CPU read: cpu_rd=1 with RX not empty SHALL load cpu_rdata with the RX head and pop it; cpu_rdata is valid one cycle after the strobe.
REQ-023 CPU read: cpu_rd=1 with RX empty SHALL load cpu_rdata with 0 and set underflow; no bypass of a same-cycle RX push.
REQ-024 RX full with cpu_rd pop and rx push in the same cycle: rx_ready stays 0, so no push; the pop proceeds.
REQ-025 cpu_rdata SHALL hold its value between reads.
REQ-026 cpu_wr and cpu_rd in the same cycle SHALL both execute independently.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Counts SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-029 overflow and underflow SHALL be sticky until a clear_flags edge.
REQ-030 A flag-setting event coincident with clear_flags SHALL leave the flag set (set wins).
REQ-031 status[1] SHALL be combinational rx_count!=0; status[0] SHALL be tx_count==DEPTH.

Reset
REQ-032 Reset SHALL asynchronously empty both FIFOs.
REQ-033 Reset SHALL set cpu_rdata=0 and clear both flags.
REQ-034 During reset, tx_valid=0, rx_ready=0, and status=0; rx_ready SHALL rise in the first cycle after reset release.
REQ-035 Reset asserted mid-transfer SHALL discard all queued words; a word handshaked in the reset cycle is lost.
REQ-036 FIFO storage arrays need not be reset.

Structure
REQ-037 Package io_port_pkg SHALL hold WIDTH, DEPTH, IO_ADDR=255, and the status bit indices.
REQ-038 A sub-module io_fifo (push/pop/full/empty/count/head) SHALL be instantiated twice, for TX and RX.
REQ-039 Flag logic and the cpu_rdata register SHALL live in the top level.

Verification
REQ-040 Reset release, then write 0x1234 and 0xBEEF with tx_ready=1 -> tx_data shows 0x1234 then 0xBEEF in order; tx_valid falls afterward.
REQ-041 tx_ready=0; 5 writes (0..4) with DEPTH=4 -> status[0]=1 after the 4th write; the 5th write is dropped and overflow=1; the drain yields 0,1,2,3.
REQ-042 TX full; cpu_wr=0xAAAA with tx_ready=1 in the same cycle -> count stays 4; 0xAAAA emerges last.
REQ-043 rx pushes 0x0055, 0x00AA, then cpu_rd twice -> cpu_rdata=0x0055 then 0x00AA; a third cpu_rd -> cpu_rdata=0 and underflow=1.
REQ-044 clear_flags pulse -> status[3:2]=0; underflow event coincident with clear_flags -> underflow stays 1.
REQ-045 RX holding 3 words plus a TX word, then reset pulsed mid-stream -> all outputs 0 during reset; rx_ready=1 and status=0 after release.
